uart_tx_arbiter: RTL and testbench

Packet-atomic round-robin arbiter that shares the single byte-wide debug UART transmitter between several byte-stream requesters, for example the debugger's data dump, its command echo and the status reporter. It sits between those requesters and the UART TX serializer. It grants the transmitter to one requester for a whole packet, terminated by a `last` byte. It paces bytes against the serializer's busy flag. It releases a stalled packet after a timeout, so one requester can never starve the others.

---
 rtl/uart_tx_arbiter.sv | 177 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//
// Packet-atomic round-robin arbiter that shares one byte-wide UART TX
// serializer between NUM_REQ byte-stream requesters. The transmitter is
// granted for a whole packet, ending with the byte flagged by req_last. Each
// byte is paced against the serializer's busy flag. A granted requester that
// stops presenting bytes mid-packet loses its grant after IDLE_TIMEOUT idle
// cycles.
//
// Ports
//   clk_in     system clock
//   reset      synchronous, active-high reset
//   req_valid  per-requester byte valid
//   req_data   per-requester byte; requester i on bits [8i+7:8i]
//   req_last   per-requester end-of-packet marker
//   req_ready  per-requester accept (combinational)
//   tx_busy    serializer busy, high from the cycle after tx_start
//   tx_start   one-cycle launch pulse for tx_data
//   tx_data    byte to the serializer, held between starts
//   grant_id   index of the current or most recent owner
//   active     a packet is in progress
//   abort      one-cycle pulse when a grant is revoked by timeout
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 2,
    parameter int IDLE_TIMEOUT = 1023
) (
    input  logic                   clk_in,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ*8-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic                   tx_busy,
    output logic                   tx_start,
    output logic [7:0]             tx_data,
    output logic [1:0]             grant_id,
    output logic                   active,
    output logic                   abort
);

    localparam int CNT_W = $clog2(IDLE_TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_BUSY,
        ST_DRAIN
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [1:0]         rr;
    logic [CNT_W-1:0]   idle_cnt;
    logic [CNT_W-1:0]   idle_cnt_inc;
    logic               last_flag;

    // Requester buses widened to the 4-requester maximum so a 2-bit index
    // always selects a legal bit; padding bits are zero and never win.
    logic [3:0]         valid4;
    logic [3:0]         last4;
    logic [31:0]        data32;

    logic               win_vld;
    logic [1:0]         win_id;
    logic               own_valid;
    logic               own_last;
    logic [7:0]         own_data;
    logic               xfer;
    logic               timeout_hit;
    logic               pkt_done;

    // (a + b) mod NUM_REQ for a, b < NUM_REQ: one conditional subtract suffices.
    function automatic logic [1:0] mod_add(input logic [1:0] a, input logic [1:0] b);
        logic [2:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= 3'(NUM_REQ)) begin
            s = s - 3'(NUM_REQ);
        end
        return s[1:0];
    endfunction

    // Idle counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    assign valid4 = 4'(req_valid);
    assign last4  = 4'(req_last);
    assign data32 = 32'(req_data);

    assign own_valid    = valid4[grant_id];
    assign own_last     = last4[grant_id];
    assign own_data     = data32[{grant_id, 3'b000} +: 8];
    assign xfer         = (state == ST_SEND) && own_valid && !tx_busy;
    assign idle_cnt_inc = sat_inc(idle_cnt);
    assign timeout_hit  = (state == ST_SEND) && !own_valid &&
                          (idle_cnt_inc >= CNT_W'(IDLE_TIMEOUT));
    assign pkt_done     = (state == ST_DRAIN) && !tx_busy && last_flag;
    assign active       = (state != ST_IDLE);

    // Round-robin search starting at rr; first valid requester wins.
    always_comb begin
        win_vld = 1'b0;
        win_id  = rr;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!win_vld && valid4[mod_add(rr, 2'(k))]) begin
                win_vld = 1'b1;
                win_id  = mod_add(rr, 2'(k));
            end
        end
    end

    // Only the owner is ever offered ready, and only while in SEND.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = (state == ST_SEND) && (grant_id == 2'(i)) &&
                           own_valid && !tx_busy;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (win_vld) state_nxt = ST_SEND;
            end
            ST_SEND: begin
                if (xfer)             state_nxt = ST_WAIT_BUSY;
                else if (timeout_hit) state_nxt = ST_IDLE;
            end
            ST_WAIT_BUSY: begin
                if (tx_busy) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!tx_busy) state_nxt = last_flag ? ST_IDLE : ST_SEND;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state     <= ST_IDLE;
            rr        <= 2'd0;
            idle_cnt  <= '0;
            last_flag <= 1'b0;
            tx_start  <= 1'b0;
            tx_data   <= 8'h00;
            grant_id  <= 2'd0;
            abort     <= 1'b0;
        end else begin
            state    <= state_nxt;
            // Registered transfer strobe lands on the first WAIT_BUSY cycle.
            tx_start <= xfer;
            abort    <= timeout_hit;

            if (state == ST_IDLE) begin
                idle_cnt <= '0;
                if (win_vld) grant_id <= win_id;
            end

            if (xfer) begin
                tx_data   <= own_data;
                last_flag <= own_last;
                idle_cnt  <= '0;
            end else if ((state == ST_SEND) && !own_valid) begin
                idle_cnt <= idle_cnt_inc;
            end

            if (pkt_done || timeout_hit) begin
                rr <= mod_add(grant_id, 2'd1);
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
//
// Directed bench for uart_tx_arbiter with two requesters and a short idle
// timeout. Requesters are byte tables walked as bytes are accepted; a small
// serializer model holds tx_busy for BUSY_LEN cycles after each tx_start.
// Every tx_start and abort is logged with its cycle number and compared
// against hand-derived expectations.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ      = 2;
    localparam int IDLE_TIMEOUT = 8;
    localparam int BUSY_LEN     = 9;

    logic tb_clk_baudrate = 1'b0;
    always #5 tb_clk_baudrate = ~tb_clk_baudrate;

    logic                 reset;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ*8-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 tx_busy;
    logic                 tx_start;
    logic [7:0]           tx_data;
    logic [1:0]           grant_id;
    logic                 active;
    logic                 abort;

    uart_tx_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .IDLE_TIMEOUT (IDLE_TIMEOUT)
    ) dut (
        .clk_in    (tb_clk_baudrate),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_busy   (tx_busy),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .grant_id  (grant_id),
        .active    (active),
        .abort     (abort)
    );

    logic [7:0] pkt_byte [2][8];
    logic       pkt_lst  [2][8];
    int         pkt_len  [2];
    logic       en       [2];
    int         pos      [2];
    logic       clr_pos = 1'b1;
    logic       hold_busy = 1'b0;
    int         busy_cnt = 0;
    int         cyc = 0;

    logic [7:0] log_data [$];
    logic [1:0] log_gid  [$];
    int         log_cyc  [$];
    int         abort_cyc[$];

    int errors = 0;
    int checks = 0;

    assign tx_busy = (busy_cnt != 0) || hold_busy;

    always_comb begin
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        for (int i = 0; i < 2; i++) begin
            if (en[i] && pos[i] < pkt_len[i]) begin
                req_valid[i]       = 1'b1;
                req_data[i*8 +: 8] = pkt_byte[i][pos[i][2:0]];
                req_last[i]        = pkt_lst[i][pos[i][2:0]];
            end
        end
    end

    always @(posedge tb_clk_baudrate) begin
        cyc <= cyc + 1;
        if (tx_start)          busy_cnt <= BUSY_LEN;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
        for (int i = 0; i < 2; i++) begin
            if (clr_pos)                          pos[i] <= 0;
            else if (req_valid[i] && req_ready[i]) pos[i] <= pos[i] + 1;
        end
        if (tx_start) begin
            log_data.push_back(tx_data);
            log_gid.push_back(grant_id);
            log_cyc.push_back(cyc);
        end
        if (abort) abort_cyc.push_back(cyc);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge tb_clk_baudrate);
        #1;
    endtask

    task automatic prep();
        en[0]   = 1'b0;
        en[1]   = 1'b0;
        clr_pos = 1'b1;
        tick();
        clr_pos = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!(pos[0] >= pkt_len[0] && pos[1] >= pkt_len[1] && !active && !tx_busy) && n < 400) begin
            tick();
            n++;
        end
        check(tag, 32'(n < 400), 32'd1);
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_tx_start"},  32'(tx_start),  32'd0);
        check({pfx, "_tx_data"},   32'(tx_data),   32'h00);
        check({pfx, "_req_ready"}, 32'(req_ready), 32'd0);
        check({pfx, "_grant_id"},  32'(grant_id),  32'd0);
        check({pfx, "_active"},    32'(active),    32'd0);
        check({pfx, "_abort"},     32'(abort),     32'd0);
    endtask

    task automatic check_log(input string pfx, input int base, input int k,
                             input logic [7:0] d, input logic [1:0] g);
        check($sformatf("%s_data%0d", pfx, k), 32'(log_data[base+k]), 32'(d));
        check($sformatf("%s_gid%0d", pfx, k),  32'(log_gid[base+k]),  32'(g));
    endtask

    initial begin
        int c;
        int base;
        int abase;
        int n;
        logic [7:0] exp_d [6];
        logic [1:0] exp_g [6];

        reset = 1'b1;
        en[0] = 1'b0;
        en[1] = 1'b0;
        pkt_len[0] = 0;
        pkt_len[1] = 0;
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 8; k++) begin
                pkt_byte[i][k] = 8'h00;
                pkt_lst[i][k]  = 1'b0;
            end
        end
        repeat (3) tick();
        check_reset_outputs("rst");
        reset   = 1'b0;
        clr_pos = 1'b0;
        tick();

        // Single two-byte packet from requester 0.
        prep();
        pkt_byte[0][0] = 8'h4C; pkt_lst[0][0] = 1'b0;
        pkt_byte[0][1] = 8'h52; pkt_lst[0][1] = 1'b1;
        pkt_len[0] = 2;
        pkt_len[1] = 0;
        base = log_data.size();
        c = cyc;
        en[0] = 1'b1;
        tick();
        check("t1_active", 32'(active), 32'd1);
        check("t1_grant", 32'(grant_id), 32'd0);
        check("t1_ready", 32'(req_ready), 32'b01);
        n = 0;
        while (active && n < 100) begin
            tick();
            n++;
        end
        check("t1_active_fall_cyc", 32'(cyc), 32'(c + 25));
        check("t1_nstart", 32'(log_data.size() - base), 32'd2);
        check("t1_start0_cyc", 32'(log_cyc[base]), 32'(c + 2));
        check("t1_start1_cyc", 32'(log_cyc[base+1]), 32'(c + 14));
        check_log("t1", base, 0, 8'h4C, 2'd0);
        check_log("t1", base, 1, 8'h52, 2'd0);

        // Contention from reset: both requesters start together.
        reset = 1'b1;
        prep();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            pkt_byte[0][k] = 8'hA0 + 8'(k); pkt_lst[0][k] = (k == 2);
            pkt_byte[1][k] = 8'hB0 + 8'(k); pkt_lst[1][k] = (k == 2);
        end
        pkt_len[0] = 3;
        pkt_len[1] = 3;
        base = log_data.size();
        en[0] = 1'b1;
        en[1] = 1'b1;
        tick();
        check("t2_grant_first", 32'(grant_id), 32'd0);
        wait_done("t2_timeout");
        exp_d = '{8'hA0, 8'hA1, 8'hA2, 8'hB0, 8'hB1, 8'hB2};
        exp_g = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1};
        check("t2_nstart", 32'(log_data.size() - base), 32'd6);
        for (int k = 0; k < 6; k++) check_log("t2", base, k, exp_d[k], exp_g[k]);

        // Fairness: requester 0 streams two packets back to back.
        reset = 1'b1;
        prep();
        reset = 1'b0;
        pkt_byte[0][0] = 8'hC0; pkt_lst[0][0] = 1'b0;
        pkt_byte[0][1] = 8'hC1; pkt_lst[0][1] = 1'b1;
        pkt_byte[0][2] = 8'hC2; pkt_lst[0][2] = 1'b0;
        pkt_byte[0][3] = 8'hC3; pkt_lst[0][3] = 1'b1;
        pkt_byte[1][0] = 8'hD0; pkt_lst[1][0] = 1'b1;
        pkt_len[0] = 4;
        pkt_len[1] = 1;
        base = log_data.size();
        en[0] = 1'b1;
        en[1] = 1'b1;
        tick();
        wait_done("t3_timeout");
        exp_d = '{8'hC0, 8'hC1, 8'hD0, 8'hC2, 8'hC3, 8'h00};
        exp_g = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0};
        check("t3_nstart", 32'(log_data.size() - base), 32'd5);
        for (int k = 0; k < 5; k++) check_log("t3", base, k, exp_d[k], exp_g[k]);

        // Timeout: owner sends one non-last byte, then goes quiet.
        reset = 1'b1;
        prep();
        reset = 1'b0;
        pkt_byte[0][0] = 8'hE0; pkt_lst[0][0] = 1'b0;
        pkt_byte[1][0] = 8'hF0; pkt_lst[1][0] = 1'b1;
        pkt_len[0] = 1;
        pkt_len[1] = 1;
        base  = log_data.size();
        abase = abort_cyc.size();
        c = cyc;
        en[0] = 1'b1;
        en[1] = 1'b1;
        tick();
        wait_done("t4_timeout");
        check("t4_nabort", 32'(abort_cyc.size() - abase), 32'd1);
        check("t4_abort_cyc", 32'(abort_cyc[abase]), 32'(c + 21));
        check("t4_nstart", 32'(log_data.size() - base), 32'd2);
        check_log("t4", base, 0, 8'hE0, 2'd0);
        check_log("t4", base, 1, 8'hF0, 2'd1);
        check("t4_start1_cyc", 32'(log_cyc[base+1]), 32'(c + 23));

        // Busy backpressure before the first start.
        reset = 1'b1;
        prep();
        reset = 1'b0;
        hold_busy = 1'b1;
        pkt_byte[0][0] = 8'h11; pkt_lst[0][0] = 1'b0;
        pkt_byte[0][1] = 8'h22; pkt_lst[0][1] = 1'b1;
        pkt_len[0] = 2;
        pkt_len[1] = 0;
        base = log_data.size();
        en[0] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("t5_ready_held%0d", k), 32'(req_ready), 32'd0);
        end
        check("t5_no_start", 32'(log_data.size() - base), 32'd0);
        hold_busy = 1'b0;
        #1;
        check("t5_ready_release", 32'(req_ready), 32'b01);
        wait_done("t5_timeout");
        check("t5_nstart", 32'(log_data.size() - base), 32'd2);
        check_log("t5", base, 0, 8'h11, 2'd0);
        check_log("t5", base, 1, 8'h22, 2'd0);

        // Reset mid-packet while requester 1 owns the transmitter (rr = 1 here).
        prep();
        pkt_byte[1][0] = 8'h33; pkt_lst[1][0] = 1'b0;
        pkt_byte[1][1] = 8'h44; pkt_lst[1][1] = 1'b1;
        pkt_byte[0][0] = 8'h55; pkt_lst[0][0] = 1'b1;
        pkt_len[0] = 1;
        pkt_len[1] = 2;
        en[1] = 1'b1;
        tick();
        check("t6_grant_owner", 32'(grant_id), 32'd1);
        repeat (5) tick();
        abase = abort_cyc.size();
        reset = 1'b1;
        tick();
        check_reset_outputs("t6");
        reset = 1'b0;
        en[0] = 1'b1;
        tick();
        check("t6_grant_after_rst", 32'(grant_id), 32'd0);
        check("t6_active_after_rst", 32'(active), 32'd1);
        wait_done("t6_timeout");
        check("t6_no_abort", 32'(abort_cyc.size() - abase), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
